// File: rtl/au_sub_seq_pkg.sv
// Shared types and sizing helpers for the chunk-serial subtractor.
package au_sub_seq_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int nchunk(input int width, input int chunk);
        return width / chunk;
    endfunction

    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/au_sub_chunk.sv
// Combinational CHUNK-bit subtractor slice: {bo,d} = x - y - bi, plus signed overflow of the slice.
module au_sub_chunk #(
    parameter int CHUNK = 8,
    parameter int ARCH  = 0
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             bi,
    output logic [CHUNK-1:0] d,
    output logic             bo,
    output logic             vo
);
    generate
        if (ARCH == 0) begin : g_rip
            assign {bo, d} = {1'b0, x} - {1'b0, y} - {{CHUNK{1'b0}}, bi};
        end else begin : g_gp
            // x - y - bi == x + ~y + ~bi; borrow is the inverted final carry
            logic [CHUNK:0]   c;
            logic [CHUNK-1:0] g;
            logic [CHUNK-1:0] p;
            assign g    = x & ~y;
            assign p    = x ^ ~y;
            assign c[0] = ~bi;
            for (genvar i = 0; i < CHUNK; i++) begin : g_c
                assign c[i+1] = g[i] | (p[i] & c[i]);
            end
            assign d  = p ^ c[CHUNK-1:0];
            assign bo = ~c[CHUNK];
        end
    endgenerate

    assign vo = (x[CHUNK-1] ^ y[CHUNK-1]) & (d[CHUNK-1] ^ x[CHUNK-1]);
endmodule

// File: rtl/au_sub_vz_seq.sv
// Chunk-serial a - b - ci with overflow/zero flags, one CHUNK slice reused per cycle.
module au_sub_vz_seq
    import au_sub_seq_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int ARCH  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_vld,
    output logic             in_rdy,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_vld,
    input  logic             out_rdy,
    output logic [WIDTH-1:0] s,
    output logic             v,
    output logic             z,
    output logic             busy
);
    localparam int NCHUNK = nchunk(WIDTH, CHUNK);
    localparam int CW     = cnt_w(NCHUNK);

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0 || ARCH < 0 || ARCH > 2)
        begin : g_bad_param
            $fatal(1, "au_sub_vz_seq: illegal WIDTH/CHUNK/ARCH");
        end
    endgenerate

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, s_q;
    logic [CW-1:0]     cnt_q;
    logic              bor_q, zacc_q, v_q, z_q;

    logic [CHUNK-1:0]  d_w;
    logic              bo_w, vo_w, zacc_d, last_w;

    // operands shift down so the active chunk always sits in the low slice
    au_sub_chunk #(.CHUNK(CHUNK), .ARCH(ARCH)) u_slice (
        .x  (a_q[CHUNK-1:0]),
        .y  (b_q[CHUNK-1:0]),
        .bi (bor_q),
        .d  (d_w),
        .bo (bo_w),
        .vo (vo_w)
    );

    assign zacc_d = zacc_q & (d_w == '0);
    assign last_w = (cnt_q == CW'(NCHUNK - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            bor_q   <= 1'b0;
            zacc_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_vld) begin
                    a_q     <= a;
                    b_q     <= b;
                    bor_q   <= ci;
                    cnt_q   <= '0;
                    zacc_q  <= 1'b1;
                    s_q     <= '0;
                    state_q <= BUSY;
                end
                BUSY: begin
                    s_q[cnt_q*CHUNK +: CHUNK] <= d_w;
                    a_q    <= a_q >> CHUNK;
                    b_q    <= b_q >> CHUNK;
                    bor_q  <= bo_w;
                    zacc_q <= zacc_d;
                    cnt_q  <= cnt_q + 1'b1;
                    if (last_w) begin
                        // a wrapped result of 0 with overflow is not a true zero
                        v_q     <= vo_w;
                        z_q     <= zacc_d & ~vo_w;
                        state_q <= DONE;
                    end
                end
                DONE: if (out_rdy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_rdy  = (state_q == IDLE);
    assign out_vld = (state_q == DONE);
    assign busy    = (state_q != IDLE);
    assign s       = s_q;
    assign v       = v_q;
    assign z       = z_q;
endmodule

// File: tb/tb_au_sub_vz_seq.sv
// Bench for au_sub_vz_seq: three configurations checked every cycle against a signed-arithmetic model.
module tb_au_sub_vz_seq;
    localparam int W  [3] = '{32, 8, 4};
    localparam int NC [3] = '{4, 1, 4};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  in_vld, out_rdy, ci, in_rdy, out_vld, busy, v, z;
    logic [31:0] a [3];
    logic [31:0] b [3];
    logic [31:0] sx [3];
    logic [31:0] s0;
    logic [7:0]  s1;
    logic [3:0]  s2;

    assign sx[0] = s0;
    assign sx[1] = {24'b0, s1};
    assign sx[2] = {28'b0, s2};

    au_sub_vz_seq #(.WIDTH(32), .CHUNK(8), .ARCH(0)) u_w32 (
        .clk(clk), .rst(rst), .in_vld(in_vld[0]), .in_rdy(in_rdy[0]), .a(a[0]), .b(b[0]), .ci(ci[0]),
        .out_vld(out_vld[0]), .out_rdy(out_rdy[0]), .s(s0), .v(v[0]), .z(z[0]), .busy(busy[0]));
    au_sub_vz_seq #(.WIDTH(8), .CHUNK(8), .ARCH(1)) u_w8 (
        .clk(clk), .rst(rst), .in_vld(in_vld[1]), .in_rdy(in_rdy[1]), .a(a[1][7:0]), .b(b[1][7:0]), .ci(ci[1]),
        .out_vld(out_vld[1]), .out_rdy(out_rdy[1]), .s(s1), .v(v[1]), .z(z[1]), .busy(busy[1]));
    au_sub_vz_seq #(.WIDTH(4), .CHUNK(1), .ARCH(2)) u_w4 (
        .clk(clk), .rst(rst), .in_vld(in_vld[2]), .in_rdy(in_rdy[2]), .a(a[2][3:0]), .b(b[2][3:0]), .ci(ci[2]),
        .out_vld(out_vld[2]), .out_rdy(out_rdy[2]), .s(s2), .v(v[2]), .z(z[2]), .busy(busy[2]));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic check(input string nm, input int inst, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] at %0t: got %h want %h", nm, inst, $time, act, exp);
        end
    endtask

    // {v, z, s}: exact signed difference, then judged against the W-bit range
    function automatic logic [33:0] ref_fn(input int w, input logic [31:0] x, input logic [31:0] y, input logic c);
        longint m, sa, sb, r;
        logic [31:0] sr;
        m  = (longint'(1) << w) - 1;
        sa = longint'(x) & m;
        sb = longint'(y) & m;
        if (sa >= (longint'(1) << (w - 1))) sa -= longint'(1) << w;
        if (sb >= (longint'(1) << (w - 1))) sb -= longint'(1) << w;
        r  = sa - sb - longint'(c);
        sr = 32'(r & m);
        return {(r < -(longint'(1) << (w - 1))) || (r >= (longint'(1) << (w - 1))), r == 0, sr};
    endfunction

    // model: 0 idle, 1 computing for NC cycles, 2 holding result
    int          mst   [3] = '{0, 0, 0};
    int          mleft [3] = '{0, 0, 0};
    int          mdone [3] = '{0, 0, 0};
    logic [33:0] expv  [3];
    logic [33:0] held  [3];

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (rst) begin
                mst[i]  <= 0;
                held[i] <= '0;
            end else begin
                case (mst[i])
                    0: if (in_vld[i]) begin
                        expv[i]  <= ref_fn(W[i], a[i], b[i], ci[i]);
                        held[i]  <= {held[i][33:32], 32'h0};
                        mleft[i] <= NC[i];
                        mst[i]   <= 1;
                    end
                    1: begin
                        mleft[i] <= mleft[i] - 1;
                        if (mleft[i] == 1) begin
                            mst[i]  <= 2;
                            held[i] <= expv[i];
                        end
                    end
                    default: if (out_rdy[i]) begin
                        mst[i]   <= 0;
                        mdone[i] <= mdone[i] + 1;
                    end
                endcase
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check("in_rdy", i, {33'b0, in_rdy[i]}, {33'b0, mst[i] == 0});
                check("out_vld", i, {33'b0, out_vld[i]}, {33'b0, mst[i] == 2});
                check("busy", i, {33'b0, busy[i]}, {33'b0, mst[i] != 0});
                check("v", i, {33'b0, v[i]}, {33'b0, held[i][33]});
                check("z", i, {33'b0, z[i]}, {33'b0, held[i][32]});
                if (mst[i] != 1) check("s", i, {2'b0, sx[i]}, {2'b0, held[i][31:0]});
            end
        end
    end

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic tci,
                          input logic [31:0] xs, input logic xv, input logic xz, input int hold);
        int lat;
        a[0] = ta; b[0] = tb; ci[0] = tci; in_vld[0] = 1'b1; out_rdy[0] = 1'b0;
        @(posedge clk); #1;
        in_vld[0] = 1'b0;
        lat = 0;
        while (out_vld[0] !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 0, 34'(lat), 34'd4);
        check("lit_s", 0, {2'b0, s0}, {2'b0, xs});
        check("lit_vz", 0, {32'b0, v[0], z[0]}, {32'b0, xv, xz});
        check("model_pin", 0, held[0], {xv, xz, xs});
        for (int k = 0; k < hold; k++) begin
            in_vld[0] = ~in_vld[0];
            a[0] = $urandom;
            @(posedge clk); #1;
            check("hold_s", 0, {2'b0, s0}, {2'b0, xs});
            check("hold_flags", 0, {31'b0, v[0], z[0], in_rdy[0]}, {31'b0, xv, xz, 1'b0});
        end
        in_vld[0] = 1'b0;
        out_rdy[0] = 1'b1;
        @(posedge clk); #1;
        out_rdy[0] = 1'b0;
        check("release", 0, {32'b0, in_rdy[0], out_vld[0]}, {32'b0, 1'b1, 1'b0});
        check("release_s", 0, {2'b0, s0}, {2'b0, xs});
    endtask

    function automatic logic [31:0] pick(input int w);
        logic [31:0] m, r;
        m = 32'hFFFF_FFFF >> (32 - w);
        case ($urandom_range(0, 7))
            0: r = 32'h0;
            1: r = m;
            2: r = 32'h1 << (w - 1);
            3: r = (32'h1 << (w - 1)) - 1;
            default: r = $urandom;
        endcase
        return r & m;
    endfunction

    initial begin
        int cyc;
        int base [3];
        rst = 1'b1;
        in_vld = '0; out_rdy = '0; ci = '0;
        for (int i = 0; i < 3; i++) begin a[i] = '0; b[i] = '0; end
        @(posedge clk); #1;
        chk_en = 1'b1;
        check("rst_state", 0, {29'b0, in_rdy[0], out_vld[0], busy[0], v[0], z[0]}, {29'b0, 5'b10000});
        check("rst_s", 0, {2'b0, s0}, 34'h0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_op(32'h0000_0100, 32'h0000_0001, 1'b0, 32'h0000_00FF, 1'b0, 1'b0, 0);
        run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1'b1, 1'b0, 0);
        run_op(32'h1234_5678, 32'h1234_5677, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 0);
        run_op(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 5);

        // reset with cnt==2, v still set from the previous result
        a[0] = 32'h1234_5678; b[0] = 32'h0; ci[0] = 1'b0; in_vld[0] = 1'b1;
        @(posedge clk); #1;
        in_vld[0] = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst_ctl", 0, {32'b0, in_rdy[0], out_vld[0]}, {32'b0, 1'b1, 1'b0});
        check("midrst_svz", 0, {v[0], z[0], s0}, 34'h0);
        rst = 1'b0;

        for (int i = 0; i < 3; i++) base[i] = mdone[i];
        cyc = 0;
        while ((mdone[0] - base[0] < 1000 || mdone[1] - base[1] < 1000 || mdone[2] - base[2] < 1000)
               && cyc < 60000) begin
            for (int i = 0; i < 3; i++) begin
                in_vld[i]  = 1'($urandom_range(0, 1));
                out_rdy[i] = 1'($urandom_range(0, 1));
                a[i]  = pick(W[i]);
                b[i]  = pick(W[i]);
                ci[i] = 1'($urandom_range(0, 1));
            end
            @(posedge clk); #1;
            cyc++;
        end
        check("random_budget", 0, {33'b0, cyc < 60000}, 34'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
